// File: rtl/md_hazard_ctrl.sv
// Decode-stage hazard unit: operand forwarding, load-use and HI/LO stalls,
// plus the MULT/DIV sequencer that owns HI/LO occupancy.
module md_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_md_valid,
    input  logic                  id_md_div,
    input  logic                  id_reads_hilo,
    input  logic [REG_ADDR_W-1:0] e_des_r,
    input  logic [REG_ADDR_W-1:0] m_des_r,
    input  logic                  e_write_reg,
    input  logic                  m_write_reg,
    input  logic                  e_mem_to_reg,
    input  logic                  m_mem_to_reg,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic                  bubble,
    output logic                  md_start,
    output logic                  md_kind,
    output logic                  md_busy,
    output logic                  md_done
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             kind_q;
    logic             start_q;

    logic             load_use;
    logic             md_struct;
    logic             hilo_use;
    logic             stall_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_load;

    // EXE wins over MEM; $0 is hard-wired so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (e_write_reg && (src == e_des_r)) begin
                sel = 2'b01;
            end else if (m_write_reg && (src == m_des_r)) begin
                sel = m_mem_to_reg ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    // Per-operand forwarding selects.
    always_comb begin
        fwd_a = fwd_sel(id_rs);
        fwd_b = fwd_sel(id_rt);
    end

    // Stall sources; a stalled MULT/DIV is retried and only issues when free.
    always_comb begin
        load_use  = e_mem_to_reg && e_write_reg && (e_des_r != '0)
                    && ((id_uses_rs && (id_rs == e_des_r))
                        || (id_uses_rt && (id_rt == e_des_r)));
        md_struct = id_md_valid && (state_q == BUSY);
        hilo_use  = id_reads_hilo && (state_q == BUSY);
        stall_d   = load_use || md_struct || hilo_use;
        accept    = id_md_valid && !stall_d;
        cnt_load  = id_md_div ? DIV_CNT : MUL_CNT;
    end

    assign stall    = stall_d;
    assign bubble   = stall_d;
    assign md_start = start_q;
    assign md_kind  = kind_q;
    assign md_busy  = (state_q == BUSY);
    assign md_done  = (state_q == DONE);

    // Sequencer: counts down the latency, then holds DONE for the HI/LO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        cnt_q   <= cnt_load;
                        kind_q  <= id_md_div;
                        start_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Scoreboard bench for md_hazard_ctrl: directed vectors queue their
// expected outputs, a negedge monitor pops and compares.
module tb_md_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, edes, mdes;
    logic       urs, urt, mdv, mdd, rhl;
    logic       ewr, mwr, emr, mmr;

    logic [1:0] fa0, fb0, fa1, fb1;
    logic       st0, bu0, sr0, kd0, bs0, dn0;
    logic       st1, bu1, sr1, kd1, bs1, dn1;

    int errors = 0;
    int checks = 0;

    string      nm_q[$];
    logic [9:0] exp_q[$];
    bit         sel_q[$];

    always #5 clk = ~clk;

    md_hazard_ctrl #(
        .REG_ADDR_W(5), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)
    ) u0 (
        .clk(clk), .rst(rst),
        .id_rs(rs), .id_rt(rt),
        .id_uses_rs(urs), .id_uses_rt(urt),
        .id_md_valid(mdv), .id_md_div(mdd),
        .id_reads_hilo(rhl),
        .e_des_r(edes), .m_des_r(mdes),
        .e_write_reg(ewr), .m_write_reg(mwr),
        .e_mem_to_reg(emr), .m_mem_to_reg(mmr),
        .fwd_a(fa0), .fwd_b(fb0),
        .stall(st0), .bubble(bu0),
        .md_start(sr0), .md_kind(kd0),
        .md_busy(bs0), .md_done(dn0)
    );

    md_hazard_ctrl #(
        .REG_ADDR_W(5), .MUL_LAT(1), .DIV_LAT(2), .CNT_W(6)
    ) u1 (
        .clk(clk), .rst(rst),
        .id_rs(rs), .id_rt(rt),
        .id_uses_rs(urs), .id_uses_rt(urt),
        .id_md_valid(mdv), .id_md_div(mdd),
        .id_reads_hilo(rhl),
        .e_des_r(edes), .m_des_r(mdes),
        .e_write_reg(ewr), .m_write_reg(mwr),
        .e_mem_to_reg(emr), .m_mem_to_reg(mmr),
        .fwd_a(fa1), .fwd_b(fb1),
        .stall(st1), .bubble(bu1),
        .md_start(sr1), .md_kind(kd1),
        .md_busy(bs1), .md_done(dn1)
    );

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            string      nm;
            logic [9:0] ev;
            logic [9:0] av;
            bit         s;
            nm = nm_q.pop_front();
            ev = exp_q.pop_front();
            s  = sel_q.pop_front();
            if (s)
                av = {fa1, fb1, st1, bu1, sr1, kd1, bs1, dn1};
            else
                av = {fa0, fb0, st0, bu0, sr0, kd0, bs0, dn0};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL %s: fa.fb.stall.bubble.start.kind.busy.done got %b required %b",
                         nm, av, ev);
            end
        end
    end

    bit dsel = 1'b0;

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic chk(input string nm, input logic [1:0] fa,
                       input logic [1:0] fb, input logic st,
                       input logic sr, input logic kd,
                       input logic bs, input logic dn);
        nm_q.push_back(nm);
        exp_q.push_back({fa, fb, st, st, sr, kd, bs, dn});
        sel_q.push_back(dsel);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs = 0; rt = 0; edes = 0; mdes = 0;
        urs = 0; urt = 0; mdv = 0; mdd = 0; rhl = 0;
        ewr = 0; mwr = 0; emr = 0; mmr = 0;
    endtask

    task automatic mult_seq(input string tag);
        mdv = 1; mdd = 0;
        chk({tag, "_issue"}, 0, 0, 0, 0, 0, 0, 0);
        mdv = 0;
        chk({tag, "_start"}, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            chk({tag, "_busy"}, 0, 0, 0, 0, 0, 1, 0);
        chk({tag, "_done"}, 0, 0, 0, 0, 0, 0, 1);
        chk({tag, "_idle"}, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 0;

        rs = 3; edes = 3; ewr = 1; mdes = 3; mmr = 1; mwr = 1;
        chk("fwd_exe_prio", 2'b01, 0, 0, 0, 0, 0, 0);
        ewr = 0;
        chk("fwd_mem_load", 2'b11, 0, 0, 0, 0, 0, 0);
        rs = 0; ewr = 1; edes = 0; mdes = 0;
        chk("fwd_zero", 0, 0, 0, 0, 0, 0, 0);
        clr();
        rt = 7; mdes = 7; mwr = 1;
        chk("fwd_b_mem_alu", 0, 2'b10, 0, 0, 0, 0, 0);
        clr();

        edes = 5; emr = 1; ewr = 1; rt = 5; urt = 1;
        chk("load_use", 0, 2'b01, 1, 0, 0, 0, 0);
        clr();
        chk("load_use_clear", 0, 0, 0, 0, 0, 0, 0);
        edes = 5; emr = 1; ewr = 1; rt = 5; urt = 0;
        chk("load_use_unused", 0, 2'b01, 0, 0, 0, 0, 0);
        edes = 0; rt = 0; urt = 1;
        chk("load_use_r0", 0, 0, 0, 0, 0, 0, 0);
        clr();

        mult_seq("mult");

        mdv = 1; mdd = 1;
        chk("div_issue", 0, 0, 0, 0, 0, 0, 0);
        mdv = 0; rhl = 1;
        for (int i = 0; i < 32; i++)
            chk("mflo_stall", 0, 0, 1, (i == 0), 1, 1, 0);
        chk("mflo_release", 0, 0, 0, 0, 1, 0, 1);
        rhl = 0;
        chk("kind_hold", 0, 0, 0, 0, 1, 0, 0);

        mdv = 1; mdd = 1;
        chk("div2_issue", 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 32; i++)
            chk("div_struct", 0, 0, 1, (i == 0), 1, 1, 0);
        chk("div_b2b_accept", 0, 0, 0, 0, 1, 0, 1);
        mdv = 0;
        for (int i = 0; i < 9; i++)
            chk("div_b2b_busy", 0, 0, 0, (i == 0), 1, 1, 0);
        rst = 1;
        chk("rst_mid_div", 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        for (int i = 0; i < 36; i++)
            chk("no_done_after_rst", 0, 0, 0, 0, 0, 0, 0);
        mult_seq("mult_after_rst");

        dsel = 1'b1;
        rst = 1;
        chk("lat1_reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        mdv = 1; mdd = 0;
        edes = 5; emr = 1; ewr = 1; rs = 5; urs = 1;
        chk("lat1_load_use", 2'b01, 0, 1, 0, 0, 0, 0);
        edes = 0; emr = 0; ewr = 0; rs = 0; urs = 0;
        chk("lat1_accept", 0, 0, 0, 0, 0, 0, 0);
        mdv = 0;
        chk("lat1_busy", 0, 0, 0, 1, 0, 1, 0);
        chk("lat1_done", 0, 0, 0, 0, 0, 0, 1);
        chk("lat1_idle", 0, 0, 0, 0, 0, 0, 0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_hazard_ctrl.md
# md_hazard_ctrl

Decode-stage hazard and multi-cycle control unit for the 5-stage pipeline. It generalises operand forwarding and load-use stalling with configurable register-address width and $0 exclusion, and adds a parametrised MULT/DIV sequencer. The sequencer tracks HI/LO occupancy and stalls conflicting instructions. It sits beside the decode stage and drives the forwarding muxes, the PC/IR hold, the EXE bubble and the HI/LO write enable.

## Interface
- REG_ADDR_W, 5, register address width
- MUL_LAT, 4, MULT/MULTU latency in cycles (≥1)
- DIV_LAT, 32, DIV/DIVU latency in cycles (≥1)
- CNT_W, 6, counter width; must hold max(MUL_LAT, DIV_LAT)-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  REG_ADDR_W  source registers in decode
- id_uses_rs, id_uses_rt  in  1  decode instruction actually reads rs / rt
- id_md_valid  in  1  decode holds MULT/MULTU/DIV/DIVU
- id_md_div  in  1  1 = divide class, 0 = multiply class
- id_reads_hilo  in  1  decode holds MFHI/MFLO
- e_des_r, m_des_r  in  REG_ADDR_W  destination register in EXE / MEM
- e_write_reg, m_write_reg  in  1  EXE / MEM writes a register
- e_mem_to_reg, m_mem_to_reg  in  1  EXE / MEM is a load
- fwd_a, fwd_b  out  2  forwarding select: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data
- stall  out  1  hold PC and IR this cycle
- bubble  out  1  inject NOP into EXE (equals stall)
- md_start  out  1  one-cycle pulse: MULT/DIV operands are in EXE; ALU latches them
- md_kind  out  1  class of the operation in flight (1 = div)
- md_busy  out  1  unit is computing
- md_done  out  1  one-cycle pulse: HI/LO write enable at the end of this cycle

## Operation
Forwarding is combinational and evaluated per operand (rs→fwd_a, rt→fwd_b).
- Register address 0 never matches; its select is 00.
- EXE match has priority over MEM: src==e_des_r && e_write_reg → 01.
- Otherwise, on src==m_des_r && m_write_reg: 11 if m_mem_to_reg, else 10.
- No match → 00.

Stall sources, combinational and ORed together:
- load_use: e_mem_to_reg && e_write_reg && e_des_r≠0 && ((id_uses_rs && id_rs==e_des_r) || (id_uses_rt && id_rt==e_des_r)).
- md_struct: id_md_valid && state==BUSY.
- hilo_use: id_reads_hilo && state==BUSY.

Issue:
- accept = id_md_valid && !stall.
- A held instruction is never accepted twice; acceptance occurs only on the non-stalled cycle.

FSM states are IDLE, BUSY, DONE.
- IDLE: on accept, go to BUSY; cnt ← LAT−1 (MUL_LAT or DIV_LAT); md_kind ← id_md_div; start_q ← 1.
- BUSY: if cnt≠0, cnt ← cnt−1. If cnt==0, go to DONE.
- DONE: on accept, go to BUSY with the same loading as IDLE. Otherwise go to IDLE.

Outputs:
- md_busy = (state==BUSY).
- md_done = (state==DONE).
- md_start = start_q; it is a registered pulse, high only in the first BUSY cycle.
- md_kind holds until the next accept.

## Timing
- Reset values: state IDLE, cnt 0, md_kind 0, md_start 0, md_busy 0, md_done 0, stall 0, bubble 0. fwd_a and fwd_b follow their inputs (00 when all inputs are 0).
- Forwarding, stall and bubble have zero latency.
- Accept at edge T gives: md_start and md_busy high in cycle T+1; BUSY for exactly LAT cycles; md_done high in cycle T+LAT+1.
- HI/LO are written at the end of the DONE cycle.
- MFHI/MFLO stalls through every BUSY cycle and proceeds in the DONE cycle. Its EXE read then follows the write.
- Back-to-back: an accept in the DONE cycle re-enters BUSY with no IDLE gap. The previous md_done still pulses.
- Reset asserted mid-operation aborts at once: no md_done, and md_busy drops asynchronously.
- Simultaneous load_use and md_struct: a single stall; the issue is not accepted.
- LAT=1: BUSY for 1 cycle (cnt starts at 0), then DONE.

## Test plan
- Forwarding priority: rs=3, e_des_r=3/e_write_reg=1, m_des_r=3/m_mem_to_reg=1/m_write_reg=1 → fwd_a=01. Drop e_write_reg → fwd_a=11. Set rs=0 with all matching → fwd_a=00.
- Load-use: e_des_r=5, e_mem_to_reg=1, e_write_reg=1, id_rt=5, id_uses_rt=1 → stall=bubble=1 in that cycle only. Repeat with id_uses_rt=0 → stall=0. Repeat with e_des_r=0 → stall=0.
- MULT with MUL_LAT=4 accepted at edge T → md_start at T+1, md_busy at T+1..T+4, md_done at T+5 and for that cycle only; md_kind=0.
- DIV with DIV_LAT=32 followed immediately by MFLO → stall held for 32 cycles, released in the DONE cycle. A second DIV issued during BUSY stalls, is accepted in DONE, and md_busy re-asserts with no gap.
- Reset at the 10th cycle of a DIV → all outputs return to reset values immediately; no md_done follows; a fresh MULT afterwards completes normally.
- MUL_LAT=1 → BUSY for 1 cycle, then DONE; a concurrent load-use stall on the issuing cycle delays acceptance by exactly one cycle.
